// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM encoding, the x0
// register index and the register-dependency helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUSY    = 2'd1,
    REFETCH = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when an enabled source operand names the given destination register.
  function automatic logic src_hits(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next value: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: produces same-cycle stall/flush controls for
// load-use hazards, EX redirects and multi-cycle EX occupancy, and keeps a
// busy watchdog plus stall/redirect performance counters.
module hazard_ctrl_unit #(
  parameter int unsigned FETCH_LATENCY = 0,
  parameter int unsigned BUSY_TIMEOUT  = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             busy_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  import hazard_pkg::*;

  localparam int unsigned     RUN_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [2:0]       FETCH_LAT = 3'(FETCH_LATENCY);
  localparam logic [RUN_W-1:0] BUSY_LIM  = RUN_W'(BUSY_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  hz_state_e        state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;

  logic load_use;
  logic redirect_acc;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_stall_c, id_ex_flush_c, ex_mem_flush_c;

  // Load-use detection against the EX-stage load destination.
  always_comb begin
    load_use = ex_mem_read && (ex_rd_addr != REG_X0) &&
               (src_hits(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                src_hits(id_uses_rs2, id_rs2_addr, ex_rd_addr));
  end

  // Next-state and raw control outputs; priority busy > redirect > load-use.
  // BUSY without ex_busy behaves exactly like RUN, so both share one branch.
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    redirect_acc   = 1'b0;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    if (ex_busy) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
      if (state_q != REFETCH) begin
        state_d = BUSY;
      end
    end else if (state_q == REFETCH) begin
      if_id_flush_c = 1'b1;
      if (ex_redirect) begin
        id_ex_flush_c = 1'b1;
        redirect_acc  = 1'b1;
        fcnt_d        = FETCH_LAT;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
        if (fcnt_q == 3'd1) begin
          state_d = RUN;
        end
      end
    end else begin
      state_d = RUN;
      if (ex_redirect) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        redirect_acc  = 1'b1;
        if (FETCH_LATENCY > 0) begin
          state_d = REFETCH;
          fcnt_d  = FETCH_LAT;
        end
      end else if (load_use) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end
    end
  end

  // FSM state and fetch-latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Busy run-length (saturating) and sticky timeout flag.
  always_comb begin
    run_d = '0;
    if (ex_busy) begin
      run_d = (run_q == BUSY_LIM) ? run_q : run_q + RUN_ONE;
    end
    timeout_d = timeout_q || (run_d == BUSY_LIM);
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  // Controls are forced low while reset is asserted, without waiting for a clock.
  assign pc_stall     = reset & pc_stall_c;
  assign if_id_stall  = reset & if_id_stall_c;
  assign if_id_flush  = reset & if_id_flush_c;
  assign id_ex_stall  = reset & id_ex_stall_c;
  assign id_ex_flush  = reset & id_ex_flush_c;
  assign ex_mem_flush = reset & ex_mem_flush_c;
  assign busy_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (reset & redirect_acc),
    .count (redirect_count)
  );

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Produces the stall/flush controls consumed by the four pipeline registers and the PC register.
- Resolves load-use hazards, EX-stage control redirects (taken branch, jal, jalr) and multi-cycle EX occupancy (ex_busy from a future divider or CSR unit).
- Sequential content: a 3-state FSM, a fetch-latency flush counter, a busy watchdog and saturating performance counters.
- Sits beside the datapath between the ID and EX decode/compare logic and the pipeline registers.

Parameters:
- FETCH_LATENCY, 0: extra cycles if_id_flush stays high after a redirect, to cover a registered instruction memory. Legal range 0..7.
- BUSY_TIMEOUT, 64: consecutive ex_busy cycles that set busy_timeout. Must be ≥ 2.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low: state is cleared while reset==0. Deassertion is synchronised externally.
- id_rs1_addr  in  5  rs1 field of the instruction in ID.
- id_rs2_addr  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- ex_busy  in  1  EX instruction needs further cycles (level signal).
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  clear the IF/ID register.
- id_ex_stall  out  1  hold the ID/EX register.
- id_ex_flush  out  1  clear the ID/EX register.
- ex_mem_flush  out  1  insert a bubble into EX/MEM.
- busy_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.
- redirect_count  out  CNT_W  count of accepted redirects.

Behaviour:
- All stall/flush outputs are combinational functions of the current state and the inputs, so they act in the same cycle.
- Counters, state and busy_timeout are registered.
- While reset==0:
  - state=RUN, fetch counter=0, busy run-length=0, busy_timeout=0, both perf counters=0.
  - Every stall/flush output is forced to 0.
- load_use = ex_mem_read & (ex_rd_addr!=0) & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- Priority within any state: ex_busy > ex_redirect > load_use.
  - While ex_busy=1 the EX instruction is not a resolved branch, so a redirect is ignored and re-presented later.
- Busy response: pc_stall=if_id_stall=id_ex_stall=1, ex_mem_flush=1, all other outputs 0.
- Redirect response: if_id_flush=id_ex_flush=1, all stalls 0 so the PC loads the target.
- Load-use response: pc_stall=if_id_stall=1, id_ex_flush=1. This gives exactly one bubble, after which the hazard self-clears.
- No event: all outputs 0.
- FSM states RUN, BUSY, REFETCH:
  - RUN → BUSY when ex_busy=1.
  - RUN → REFETCH when ex_redirect=1, ex_busy=0 and FETCH_LATENCY>0. The fetch counter loads FETCH_LATENCY.
  - RUN → RUN otherwise.
  - BUSY → RUN when ex_busy=0. Outputs in that cycle are evaluated as in RUN, so the release cycle has no stall.
  - REFETCH: if_id_flush=1 every cycle and load_use is not evaluated. The counter decrements and the FSM returns to RUN after the cycle in which the counter reads 1.
  - REFETCH with a new ex_redirect: the counter reloads FETCH_LATENCY.
  - REFETCH with ex_busy=1: the busy response applies, the counter freezes, and the FSM stays in REFETCH.
- Watchdog:
  - The busy run-length counter increments on each cycle with ex_busy=1 and clears on ex_busy=0.
  - busy_timeout sets when the run-length reaches BUSY_TIMEOUT and clears only on reset.
  - The counter saturates at BUSY_TIMEOUT.
- Performance counters:
  - stall_cycles += 1 on each cycle with pc_stall=1.
  - redirect_count += 1 on each accepted redirect; REFETCH reloads count too.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-busy or mid-REFETCH: the FSM returns to RUN immediately and the outputs drop to 0 asynchronously.

Decomposition:
- Shared package (hazard_pkg): the FSM state encoding (RUN=2'd0, BUSY=2'd1, REFETCH=2'd2) and the constant REG_X0=5'd0.
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). It is instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cycles=1.
- x0 load: the same with ex_rd=0 → all outputs 0; stall_cycles unchanged.
- Redirect with FETCH_LATENCY=2: ex_redirect pulse at cycle N → cycle N: if_id_flush=id_ex_flush=1. Cycles N+1 and N+2: if_id_flush=1. Cycle N+3: RUN, all 0. redirect_count=1.
- Busy plus simultaneous load_use and redirect: ex_busy=1 for 3 cycles → pc/if_id/id_ex stall and ex_mem_flush=1 for 3 cycles, no flush of IF/ID; stall_cycles=3; the 4th cycle evaluates RUN.
- Watchdog with BUSY_TIMEOUT=4: ex_busy high for 4 cycles → busy_timeout=1 from cycle 5 and stays 1 after ex_busy drops; reset=0 clears it.
- Reset mid-REFETCH: assert reset=0 on the cycle after a redirect → if_id_flush drops to 0 without a clock edge; after release the state is RUN and both counters are 0.
